pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, the fetch address loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port stall, input, 1, hold fetch PC this cycle.
REQ-005 SHALL have port br_valid, input, 1, redirect request from decode.
REQ-006 SHALL have port br_ready, output, 1, request accepted this cycle.
REQ-007 SHALL have port br_kind, input, 3: 001 conditional branch, 010 jump imm26, 100 jump register; other values mean no redirect.
REQ-008 SHALL have port cond_sel, input, 3, one-hot {bnez, bgtz, beq}, used only when br_kind=001.
REQ-009 SHALL have ports zero and gtz, input, 1 each, ALU flags for rs==rt (or rs==0) and rs>0.
REQ-010 SHALL have port br_link, input, 1, request writes return address when taken.
REQ-011 SHALL have ports br_pc, ext_imm32 and rs_val, each input, 32; and imm26, input, 26; all are operands of the request.
REQ-012 SHALL have ports pc and pc4, output, 32, the fetch address and fetch address + 4.
REQ-013 SHALL have ports flush (output, 1), link_we (output, 1) and link_addr (output, 32).
REQ-014 SHALL have port redirect_cnt, output, 32, count of taken redirects.

Function
REQ-015 Taken: br_kind=010 or 100 always; br_kind=001 if (beq&zero)|(bgtz&gtz)|(bnez&~zero).
REQ-016 Targets: 001 -> br_pc+4+(ext_imm32<<2), mod 2^32; 010 -> {br_pc[31:28],imm26,2'b00}; 100 -> rs_val unmodified.
REQ-017 FSM states RUN and PEND; reset enters RUN.
REQ-018 RUN, stall=0: pc <= taken accepted target, else pc+4.
REQ-019 RUN, stall=1: pc holds; an accepted taken request latches its target into pend_target and the FSM moves to PEND.
REQ-020 PEND: br_ready=0 and pc holds; on the first cycle with stall=0, pc <= pend_target and the FSM returns to RUN.
REQ-021 br_ready = (state==RUN), combinationally; a request completes only when br_valid&br_ready.
REQ-022 A not-taken accepted request causes no state change other than normal pc advance or hold.
REQ-023 link_we SHALL be a one-cycle registered pulse in the cycle after an accepted taken request with br_link=1; link_addr is registered in the same cycle.
REQ-024 redirect_cnt SHALL increment by 1 per accepted taken request and wrap 32'hFFFF_FFFF -> 0.
REQ-025 pc4 SHALL equal pc+4 combinationally.

Reset
REQ-026 On reset: pc=RESET_PC, state=RUN, pend_target=0, flush=0, link_we=0, link_addr=0, redirect_cnt=0.
REQ-027 Reset SHALL override stall and br_valid; a PEND redirect is discarded.

Configuration
REQ-028 Macro DELAY_SLOT_EN, when defined: one architectural delay slot; flush tied 0; link_addr=br_pc+8.
REQ-029 Macro DELAY_SLOT_EN, when undefined: flush SHALL be a registered one-cycle pulse after each accepted taken request, killing the wrong-path fetch; link_addr=br_pc+4.

Structure
REQ-030 A shared package SHALL hold the br_kind encodings (001/010/100), the cond_sel bit positions and the RESET_PC default.
REQ-031 Sub-module br_target_calc SHALL be the only sub-module; it is combinational and computes taken and target.

Verification
REQ-032 Reset, then 3 cycles with no requests -> pc 3000, 3004, 3008, 300C.
REQ-033 beq with br_pc=3004, zero=1, ext_imm32=FFFF_FFFF, stall=0 -> next pc=3004; redirect_cnt=1.
REQ-034 jr with rs_val=0000_4000 while stall=1 for 2 cycles -> br_ready=0 during PEND; pc=4000 one cycle after stall drops.
REQ-035 bnez+br_link, zero=0, br_pc=3010 -> link_we pulse next cycle; link_addr=3018 (DELAY_SLOT_EN) or 3014 with flush=1 (undefined).
REQ-036 Reset asserted in PEND -> pc=3000, pending target dropped, redirect_cnt=0.
REQ-037 j with imm26=0x0000100, br_pc=F000_0000 -> pc=F000_0400.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
// Shared definitions for the fetch-PC sequencer:
//   - br_kind encodings: conditional branch, jump imm26, jump register
//   - cond_sel bit positions inside the one-hot {bnez, bgtz, beq} field
//   - the default reset fetch address
//   - FSM state type
package pc_sequencer_pkg;

  localparam logic [2:0] BR_KIND_COND = 3'b001;
  localparam logic [2:0] BR_KIND_JIMM = 3'b010;
  localparam logic [2:0] BR_KIND_JREG = 3'b100;

  localparam int COND_BEQ  = 0;
  localparam int COND_BGTZ = 1;
  localparam int COND_BNEZ = 2;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_br_target_calc.sv
// br_target_calc
// Combinational branch resolution: decides whether a redirect request is
// taken and computes its target address.
// Ports:
//   br_kind   [2:0]  request kind (cond / jump imm26 / jump register)
//   cond_sel  [2:0]  one-hot {bnez, bgtz, beq}, only meaningful for cond
//   zero, gtz        ALU flags
//   br_pc     [31:0] PC of the branch instruction
//   ext_imm32 [31:0] sign-extended word offset for conditional branches
//   rs_val    [31:0] register target for jump register
//   imm26     [25:0] jump immediate
//   taken            request redirects fetch
//   target    [31:0] redirect address (0 when not a redirect kind)
module br_target_calc
  import pc_sequencer_pkg::*;
(
  input  logic [2:0]  br_kind,
  input  logic [2:0]  cond_sel,
  input  logic        zero,
  input  logic        gtz,
  input  logic [31:0] br_pc,
  input  logic [31:0] ext_imm32,
  input  logic [31:0] rs_val,
  input  logic [25:0] imm26,
  output logic        taken,
  output logic [31:0] target
);

  logic cond_true;

  assign cond_true = (cond_sel[COND_BEQ]  &  zero) |
                     (cond_sel[COND_BGTZ] &  gtz)  |
                     (cond_sel[COND_BNEZ] & ~zero);

  always_comb begin
    taken  = 1'b0;
    target = '0;
    case (br_kind)
      BR_KIND_COND: begin
        taken  = cond_true;
        // Offset is a word count; the sum wraps naturally at 32 bits.
        target = br_pc + 32'd4 + (ext_imm32 << 2);
      end
      BR_KIND_JIMM: begin
        taken  = 1'b1;
        target = {br_pc[31:28], imm26, 2'b00};
      end
      BR_KIND_JREG: begin
        taken  = 1'b1;
        target = rs_val;
      end
      default: begin
        taken  = 1'b0;
        target = '0;
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Fetch PC sequencer with a one-entry pending redirect used while fetch is
// stalled.
// Build option: macro DELAY_SLOT_EN selects one architectural delay slot
// (flush tied low, link address br_pc+8). Without it, flush pulses after
// every accepted taken redirect and the link address is br_pc+4.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   stall                    hold fetch PC this cycle
//   br_valid / br_ready      redirect request handshake
//   br_kind, cond_sel        request kind and condition select
//   zero, gtz                ALU flags
//   br_link                  taken request writes a return address
//   br_pc, ext_imm32, rs_val, imm26   request operands
//   pc, pc4                  fetch address and fetch address + 4
//   flush                    kill the wrong-path fetch
//   link_we, link_addr       return-address write
//   redirect_cnt             count of accepted taken redirects
//
// state | meaning
// RUN   | normal fetch; requests accepted
// PEND  | taken redirect held in pend_target until stall drops
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [2:0]  br_kind,
  input  logic [2:0]  cond_sel,
  input  logic        zero,
  input  logic        gtz,
  input  logic        br_link,
  input  logic [31:0] br_pc,
  input  logic [31:0] ext_imm32,
  input  logic [31:0] rs_val,
  input  logic [25:0] imm26,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        flush,
  output logic        link_we,
  output logic [31:0] link_addr,
  output logic [31:0] redirect_cnt
);

`ifdef DELAY_SLOT_EN
  localparam logic [31:0] LINK_OFS = 32'd8;
`else
  localparam logic [31:0] LINK_OFS = 32'd4;
`endif

  seq_state_t  state;
  logic [31:0] pend_target;
  logic        calc_taken;
  logic [31:0] calc_target;
  logic        take;

  br_target_calc u_calc (
    .br_kind   (br_kind),
    .cond_sel  (cond_sel),
    .zero      (zero),
    .gtz       (gtz),
    .br_pc     (br_pc),
    .ext_imm32 (ext_imm32),
    .rs_val    (rs_val),
    .imm26     (imm26),
    .taken     (calc_taken),
    .target    (calc_target)
  );

  assign br_ready = (state == ST_RUN);
  assign take     = br_valid & br_ready & calc_taken;
  assign pc4      = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_RUN;
      pc           <= RESET_PC;
      pend_target  <= '0;
      link_we      <= 1'b0;
      link_addr    <= '0;
      redirect_cnt <= '0;
    end else begin
      link_we <= take & br_link;
      if (take) begin
        redirect_cnt <= redirect_cnt + 32'd1;
        if (br_link) link_addr <= br_pc + LINK_OFS;
      end
      case (state)
        ST_RUN: begin
          if (!stall) begin
            pc <= take ? calc_target : pc4;
          end else if (take) begin
            pend_target <= calc_target;
            state       <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (!stall) begin
            pc    <= pend_target;
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef DELAY_SLOT_EN
  assign flush = 1'b0;
`else
  always_ff @(posedge clk) begin
    if (reset) flush <= 1'b0;
    else       flush <= take;
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_kind;
  logic [2:0]  cond_sel;
  logic        zero;
  logic        gtz;
  logic        br_link;
  logic [31:0] br_pc;
  logic [31:0] ext_imm32;
  logic [31:0] rs_val;
  logic [25:0] imm26;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        flush;
  logic        link_we;
  logic [31:0] link_addr;
  logic [31:0] redirect_cnt;

  int n_checks = 0;
  int n_errors = 0;

`ifdef DELAY_SLOT_EN
  localparam logic [31:0] EXP_LINK  = 32'h0000_3018;
  localparam logic [31:0] EXP_FLUSH = 32'd0;
`else
  localparam logic [31:0] EXP_LINK  = 32'h0000_3014;
  localparam logic [31:0] EXP_FLUSH = 32'd1;
`endif

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .br_valid     (br_valid),
    .br_ready     (br_ready),
    .br_kind      (br_kind),
    .cond_sel     (cond_sel),
    .zero         (zero),
    .gtz          (gtz),
    .br_link      (br_link),
    .br_pc        (br_pc),
    .ext_imm32    (ext_imm32),
    .rs_val       (rs_val),
    .imm26        (imm26),
    .pc           (pc),
    .pc4          (pc4),
    .flush        (flush),
    .link_we      (link_we),
    .link_addr    (link_addr),
    .redirect_cnt (redirect_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    br_valid  = 1'b0;
    br_kind   = 3'b000;
    cond_sel  = 3'b000;
    br_link   = 1'b0;
    zero      = 1'b0;
    gtz       = 1'b0;
    stall     = 1'b0;
  endtask

  initial begin
    idle();
    reset     = 1'b1;
    br_pc     = '0;
    ext_imm32 = '0;
    rs_val    = '0;
    imm26     = '0;
    step();
    step();
    check("rst_pc",      pc,           32'h0000_3000);
    check("rst_pc4",     pc4,          32'h0000_3004);
    check("rst_ready",   {31'd0, br_ready}, 32'd1);
    check("rst_flush",   {31'd0, flush},    32'd0);
    check("rst_link_we", {31'd0, link_we},  32'd0);
    check("rst_link",    link_addr,    32'd0);
    check("rst_cnt",     redirect_cnt, 32'd0);

    // Free-running fetch
    reset = 1'b0;
    step(); check("seq_pc1", pc, 32'h0000_3004);
    step(); check("seq_pc2", pc, 32'h0000_3008);
    step(); check("seq_pc3", pc, 32'h0000_300C);

    // beq taken, negative offset: 3004+4-4 = 3004
    br_valid = 1'b1; br_kind = 3'b001; cond_sel = 3'b001; zero = 1'b1;
    br_pc = 32'h0000_3004; ext_imm32 = 32'hFFFF_FFFF;
    step();
    check("beq_pc",    pc,           32'h0000_3004);
    check("beq_cnt",   redirect_cnt, 32'd1);
    check("beq_flush", {31'd0, flush}, EXP_FLUSH);
    check("beq_lwe",   {31'd0, link_we}, 32'd0);
    idle();
    step();
    check("beq_after_pc",    pc, 32'h0000_3008);
    check("beq_after_flush", {31'd0, flush}, 32'd0);

    // beq not taken: plain advance, no count
    br_valid = 1'b1; br_kind = 3'b001; cond_sel = 3'b001; zero = 1'b0;
    step();
    check("beq_nt_pc",  pc, 32'h0000_300C);
    check("beq_nt_cnt", redirect_cnt, 32'd1);
    check("beq_nt_flush", {31'd0, flush}, 32'd0);

    // jr during stall -> PEND; request in PEND must not be accepted
    idle();
    br_valid = 1'b1; br_kind = 3'b100; rs_val = 32'h0000_4000; stall = 1'b1;
    step();
    check("jr_hold_pc", pc, 32'h0000_300C);
    check("jr_pend_ready", {31'd0, br_ready}, 32'd0);
    check("jr_cnt", redirect_cnt, 32'd2);
    br_kind = 3'b010; imm26 = 26'h3FF_FFFF;
    step();
    check("pend_hold_pc", pc, 32'h0000_300C);
    check("pend_ready2", {31'd0, br_ready}, 32'd0);
    check("pend_no_accept_cnt", redirect_cnt, 32'd2);
    idle();
    step();
    check("pend_release_pc", pc, 32'h0000_4000);
    check("pend_release_ready", {31'd0, br_ready}, 32'd1);
    step();
    check("after_jr_pc", pc, 32'h0000_4004);

    // bnez with link: 3010+4+(0x10<<2) = 3054
    br_valid = 1'b1; br_kind = 3'b001; cond_sel = 3'b100; zero = 1'b0;
    br_link = 1'b1; br_pc = 32'h0000_3010; ext_imm32 = 32'h0000_0010;
    step();
    check("bnez_pc",    pc, 32'h0000_3054);
    check("bnez_lwe",   {31'd0, link_we}, 32'd1);
    check("bnez_link",  link_addr, EXP_LINK);
    check("bnez_flush", {31'd0, flush}, EXP_FLUSH);
    check("bnez_cnt",   redirect_cnt, 32'd3);
    idle();
    step();
    check("bnez_lwe_end",  {31'd0, link_we}, 32'd0);
    check("bnez_link_hold", link_addr, EXP_LINK);
    check("bnez_after_pc", pc, 32'h0000_3058);

    // bgtz not taken with link: no link pulse
    br_valid = 1'b1; br_kind = 3'b001; cond_sel = 3'b010; gtz = 1'b0; zero = 1'b1;
    br_link = 1'b1; br_pc = 32'h0000_5000;
    step();
    check("bgtz_nt_pc",  pc, 32'h0000_305C);
    check("bgtz_nt_lwe", {31'd0, link_we}, 32'd0);
    check("bgtz_nt_link", link_addr, EXP_LINK);

    // bgtz taken: 5000+4+(1<<2) = 5008
    gtz = 1'b1; br_link = 1'b0; ext_imm32 = 32'h0000_0001;
    step();
    check("bgtz_pc", pc, 32'h0000_5008);
    check("bgtz_cnt", redirect_cnt, 32'd4);

    // j imm26
    idle();
    br_valid = 1'b1; br_kind = 3'b010; imm26 = 26'h000_0100; br_pc = 32'hF000_0000;
    step();
    check("j_pc",  pc, 32'hF000_0400);
    check("j_cnt", redirect_cnt, 32'd5);

    // Undefined kind: no redirect
    br_kind = 3'b011;
    step();
    check("badkind_pc",  pc, 32'hF000_0404);
    check("badkind_cnt", redirect_cnt, 32'd5);

    // Reset while in PEND drops the pending target
    idle();
    br_valid = 1'b1; br_kind = 3'b100; rs_val = 32'h0000_8000; stall = 1'b1;
    step();
    check("pend2_ready", {31'd0, br_ready}, 32'd0);
    reset = 1'b1;
    step();
    check("rst_pend_pc",    pc, 32'h0000_3000);
    check("rst_pend_ready", {31'd0, br_ready}, 32'd1);
    check("rst_pend_cnt",   redirect_cnt, 32'd0);
    check("rst_pend_flush", {31'd0, flush}, 32'd0);
    reset = 1'b0;
    idle();
    step();
    check("rst_pend_drop_pc", pc, 32'h0000_3004);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
